// File: rtl/ovr_i_pkg.sv
// rtl/ovr_i_pkg.sv - shared types and default parameters for the over-current monitor
package ovr_i_pkg;

    // Monitor state: IDLE (disabled), ARMED (counting), TRIPPED (shutdown latched)
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2
    } ovr_i_state_t;

    localparam int TRIP_PERIODS_DEF = 32;
    localparam int FILT_CLKS_DEF    = 4;

endpackage

// File: rtl/ovr_i_side_qual.sv
// rtl/ovr_i_side_qual.sv - per-side over-current qualifier (sync, run-length filter, period counter)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_cnt_i       hold filter, hit flag and period counter at zero (monitor not armed)
//   pwm_synch_i     1-clk pulse at start of each PWM period
//   blank_i         sensing ignored while high
//   ovr_i_raw_i     raw asynchronous over-current flag
//   trip_o          1-clk pulse: consecutive faulted periods reached TRIP_PERIODS
module ovr_i_side_qual
    import ovr_i_pkg::*;
#(
    parameter int TRIP_PERIODS = TRIP_PERIODS_DEF,
    parameter int FILT_CLKS    = FILT_CLKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_cnt_i,
    input  logic pwm_synch_i,
    input  logic blank_i,
    input  logic ovr_i_raw_i,
    output logic trip_o
);

    localparam int CW = $clog2(TRIP_PERIODS + 1);
    localparam int FW = $clog2(FILT_CLKS + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(TRIP_PERIODS);
    localparam logic [CW-1:0] CNT_PRE = CW'(TRIP_PERIODS - 1);
    localparam logic [FW-1:0] RUN_MAX = FW'(FILT_CLKS);
    localparam logic [FW-1:0] RUN_PRE = FW'(FILT_CLKS - 1);

    logic          meta_q, sync_q;
    logic [FW-1:0] run_q, run_d;
    logic          hit_q, hit_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic qualified;
    logic hit_now;
    logic period_hit;

    // Two-flop synchroniser; everything downstream sees sync_q only
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= ovr_i_raw_i;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        qualified  = sync_q & ~blank_i;
        // A run completing on this clk counts immediately, so a hit that
        // lands on the PWM_synch clk still belongs to the ending period.
        hit_now    = ~clr_cnt_i & qualified & (run_q >= RUN_PRE);
        period_hit = hit_q | hit_now;

        run_d  = run_q;
        hit_d  = hit_q | hit_now;
        cnt_d  = cnt_q;
        trip_o = 1'b0;

        if (clr_cnt_i || !qualified) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end

        if (clr_cnt_i) begin
            hit_d = 1'b0;
            cnt_d = '0;
        end else if (pwm_synch_i) begin
            hit_d = 1'b0;
            if (period_hit) begin
                cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                trip_o = (cnt_q >= CNT_PRE);
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
            hit_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            hit_q <= hit_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ovr_i_monitor.sv
// rtl/ovr_i_monitor.sv - over-current trip monitor with latched motor shutdown
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              balance controller enabled
//   PWM_synch       1-clk pulse at start of each PWM period
//   ovr_I_blank     switching-edge blanking window
//   OVR_I_lft/rght  raw asynchronous over-current flags
//   clr_fault       clear latched trip (only acted on while en=0)
//   ovr_I_shtdwn    latched shutdown to motor driver
//   fault_lft/rght  side(s) responsible for the trip
//   armed           monitor is in ARMED
module ovr_i_monitor
    import ovr_i_pkg::*;
#(
    parameter int TRIP_PERIODS = TRIP_PERIODS_DEF,
    parameter int FILT_CLKS    = FILT_CLKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic PWM_synch,
    input  logic ovr_I_blank,
    input  logic OVR_I_lft,
    input  logic OVR_I_rght,
    input  logic clr_fault,
    output logic ovr_I_shtdwn,
    output logic fault_lft,
    output logic fault_rght,
    output logic armed
);

    ovr_i_state_t state_q, state_d;
    logic         shtdwn_q, shtdwn_d;
    logic         fault_lft_q, fault_lft_d;
    logic         fault_rght_q, fault_rght_d;

    logic clr_cnt;
    logic trip_lft, trip_rght;

    // Counters only run while ARMED; IDLE and TRIPPED hold them at zero
    assign clr_cnt = (state_q != ARMED);

    ovr_i_side_qual #(
        .TRIP_PERIODS (TRIP_PERIODS),
        .FILT_CLKS    (FILT_CLKS)
    ) u_qual_lft (
        .clk         (clk),
        .rst         (rst),
        .clr_cnt_i   (clr_cnt),
        .pwm_synch_i (PWM_synch),
        .blank_i     (ovr_I_blank),
        .ovr_i_raw_i (OVR_I_lft),
        .trip_o      (trip_lft)
    );

    ovr_i_side_qual #(
        .TRIP_PERIODS (TRIP_PERIODS),
        .FILT_CLKS    (FILT_CLKS)
    ) u_qual_rght (
        .clk         (clk),
        .rst         (rst),
        .clr_cnt_i   (clr_cnt),
        .pwm_synch_i (PWM_synch),
        .blank_i     (ovr_I_blank),
        .ovr_i_raw_i (OVR_I_rght),
        .trip_o      (trip_rght)
    );

    always_comb begin
        state_d      = state_q;
        shtdwn_d     = shtdwn_q;
        fault_lft_d  = fault_lft_q;
        fault_rght_d = fault_rght_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // A trip outranks en dropping on the same clk
                if (trip_lft || trip_rght) begin
                    state_d      = TRIPPED;
                    shtdwn_d     = 1'b1;
                    fault_lft_d  = trip_lft;
                    fault_rght_d = trip_rght;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            TRIPPED: begin
                if (!en && clr_fault) begin
                    state_d      = IDLE;
                    shtdwn_d     = 1'b0;
                    fault_lft_d  = 1'b0;
                    fault_rght_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shtdwn_q     <= 1'b0;
            fault_lft_q  <= 1'b0;
            fault_rght_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shtdwn_q     <= shtdwn_d;
            fault_lft_q  <= fault_lft_d;
            fault_rght_q <= fault_rght_d;
        end
    end

    assign ovr_I_shtdwn = shtdwn_q;
    assign fault_lft    = fault_lft_q;
    assign fault_rght   = fault_rght_q;
    assign armed        = (state_q == ARMED);

endmodule

// File: tb/tb_ovr_i_monitor.sv
// tb/tb_ovr_i_monitor.sv - directed self-checking bench for ovr_i_monitor
module tb_ovr_i_monitor;

    logic clk = 1'b0;
    logic rst, en, PWM_synch, ovr_I_blank, OVR_I_lft, OVR_I_rght, clr_fault;
    logic ovr_I_shtdwn, fault_lft, fault_rght, armed;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int PER_CLKS   = 16;
    localparam int BLANK_CLKS = 6;

    // Per-period OVR_I drive patterns
    localparam int M_NONE  = 0;  // never high
    localparam int M_BLANK = 1;  // high only inside blank (after sync delay too)
    localparam int M_FAULT = 2;  // 8 clks high outside blank -> hit
    localparam int M_SHORT = 3;  // 3 clks high outside blank -> below filter

    always #5 clk = ~clk;

    ovr_i_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .PWM_synch    (PWM_synch),
        .ovr_I_blank  (ovr_I_blank),
        .OVR_I_lft    (OVR_I_lft),
        .OVR_I_rght   (OVR_I_rght),
        .clr_fault    (clr_fault),
        .ovr_I_shtdwn (ovr_I_shtdwn),
        .fault_lft    (fault_lft),
        .fault_rght   (fault_rght),
        .armed        (armed)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic drv(input int mode, input int c);
        case (mode)
            M_BLANK: return (c < 4);
            M_FAULT: return (c >= BLANK_CLKS) && (c < BLANK_CLKS + 8);
            M_SHORT: return (c >= BLANK_CLKS) && (c < BLANK_CLKS + 3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_period(input int lm, input int rm);
        for (int c = 0; c < PER_CLKS; c++) begin
            PWM_synch   = (c == 0);
            ovr_I_blank = (c < BLANK_CLKS);
            OVR_I_lft   = drv(lm, c);
            OVR_I_rght  = drv(rm, c);
            tick();
        end
        PWM_synch  = 1'b0;
        OVR_I_lft  = 1'b0;
        OVR_I_rght = 1'b0;
    endtask

    task automatic run_periods(input int n, input int lm, input int rm);
        for (int i = 0; i < n; i++) run_period(lm, rm);
    endtask

    // Lone PWM_synch that closes the previous period's evaluation
    task automatic synch_only();
        PWM_synch   = 1'b1;
        ovr_I_blank = 1'b1;
        OVR_I_lft   = 1'b0;
        OVR_I_rght  = 1'b0;
        tick();
        PWM_synch = 1'b0;
    endtask

    task automatic clear_and_rearm();
        en = 1'b0;
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        en = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; PWM_synch = 1'b0; ovr_I_blank = 1'b0;
        OVR_I_lft = 1'b1; OVR_I_rght = 1'b0; clr_fault = 1'b0;

        // Reset with left flag asserted
        tick(); tick();
        chk("rst_shtdwn", ovr_I_shtdwn, 1'b0);
        chk("rst_fault_lft", fault_lft, 1'b0);
        chk("rst_fault_rght", fault_rght, 1'b0);
        chk("rst_armed", armed, 1'b0);
        rst = 1'b0; OVR_I_lft = 1'b0;

        en = 1'b1;
        tick();
        chk("arm", armed, 1'b1);

        // Activity only inside blank never trips
        run_periods(45, M_BLANK, M_NONE);
        synch_only();
        chk("blank_no_trip", ovr_I_shtdwn, 1'b0);

        // Left faulted: trip exactly after the 32nd period is evaluated
        run_periods(32, M_FAULT, M_NONE);
        chk("lft_pre_trip", ovr_I_shtdwn, 1'b0);
        synch_only();
        chk("lft_trip_shtdwn", ovr_I_shtdwn, 1'b1);
        chk("lft_trip_fault_lft", fault_lft, 1'b1);
        chk("lft_trip_fault_rght", fault_rght, 1'b0);
        chk("lft_trip_armed", armed, 1'b0);

        // TRIPPED ignores further activity and clr_fault while en=1
        run_periods(2, M_NONE, M_FAULT);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("clr_en1_shtdwn", ovr_I_shtdwn, 1'b1);
        chk("clr_en1_fault_rght", fault_rght, 1'b0);
        en = 1'b0;
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("clr_shtdwn", ovr_I_shtdwn, 1'b0);
        chk("clr_fault_lft", fault_lft, 1'b0);
        chk("clr_armed", armed, 1'b0);
        en = 1'b1;
        tick();
        chk("rearm", armed, 1'b1);

        // Right: 31 faulted, 1 clean, 31 faulted -> no trip; 32nd -> trip
        run_periods(31, M_NONE, M_FAULT);
        run_period(M_NONE, M_NONE);
        run_periods(32, M_NONE, M_FAULT);
        chk("rght_gap_no_trip", ovr_I_shtdwn, 1'b0);
        synch_only();
        chk("rght_trip_shtdwn", ovr_I_shtdwn, 1'b1);
        chk("rght_trip_fault_rght", fault_rght, 1'b1);
        chk("rght_trip_fault_lft", fault_lft, 1'b0);
        clear_and_rearm();

        // Both sides together -> both fault flags
        run_periods(32, M_FAULT, M_FAULT);
        chk("both_pre_trip", ovr_I_shtdwn, 1'b0);
        synch_only();
        chk("both_shtdwn", ovr_I_shtdwn, 1'b1);
        chk("both_fault_lft", fault_lft, 1'b1);
        chk("both_fault_rght", fault_rght, 1'b1);
        clear_and_rearm();

        // 3-clk pulses are below the filter length
        run_periods(45, M_SHORT, M_SHORT);
        synch_only();
        chk("short_no_trip", ovr_I_shtdwn, 1'b0);
        chk("short_armed", armed, 1'b1);

        // Reset at count 20 -> the next trip needs a full 32 periods
        run_periods(21, M_FAULT, M_NONE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_armed", armed, 1'b0);
        chk("midrst_shtdwn", ovr_I_shtdwn, 1'b0);
        tick();
        chk("midrst_rearm", armed, 1'b1);
        run_periods(32, M_FAULT, M_NONE);
        chk("midrst_31_no_trip", ovr_I_shtdwn, 1'b0);
        synch_only();
        chk("midrst_32_trip", ovr_I_shtdwn, 1'b1);
        chk("midrst_fault_lft", fault_lft, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
